// File: rtl/bitonic_pkg.sv
// Shared constants and FSM state encoding for the bitonic block loader.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package bitonic_pkg;

    localparam int N_ELEM = 16;   // elements per bitonic block
    localparam int HALF   = 8;    // length of each ascending input run
    localparam int IDX_W  = 4;    // width of the element counter

    typedef enum logic {
        LOAD = 1'b0,
        HOLD = 1'b1
    } state_t;

endpackage

// File: rtl/bitonic_loader_16.sv
// Serial-to-parallel loader: packs two ascending 8-runs into one 16-slot bitonic block.
// Latency: out_valid rises one cycle after the 16th accepted element.
// Backpressure: in_ready drops while a block is held; the block is held until out_ready.
//
// Ports:
//   clk, rst             single clock, asynchronous active-high reset
//   in_valid/in_ready    serial element handshake, in_data = one unsigned element
//   out_valid/out_ready  block handshake, out_data slot s at [s*DATA_WIDTH +: DATA_WIDTH]
//   run_err              sticky flag: an element was smaller than its run predecessor
// Optional feature: define BITONIC_RUN_CHECK_EN to build the run-order checker;
// otherwise run_err is tied low and no comparator is built.
module bitonic_loader_16
    import bitonic_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [DATA_WIDTH-1:0]        in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [N_ELEM*DATA_WIDTH-1:0] out_data,
    output logic                         run_err
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ELEM - 1);
    localparam logic [IDX_W-1:0] HALF_IDX = IDX_W'(HALF);
    // Second-run elements k = 8..15 land in slot 23-k; modulo 2^IDX_W this is
    // MIRROR - k, so the subtraction can be done at counter width.
    localparam logic [IDX_W-1:0] MIRROR   = IDX_W'(N_ELEM + HALF - 1);

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q;
    logic [IDX_W-1:0]        wr_slot;
    logic [DATA_WIDTH-1:0]   slot_q [N_ELEM];
    logic                    in_fire;

    // First run fills slots 0..7 upward, second run fills 15..8 downward,
    // turning two ascending runs into ascending-then-descending order.
    assign wr_slot = (idx_q < HALF_IDX) ? idx_q : (MIRROR - idx_q);
    assign in_fire = in_valid & in_ready;

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid && (idx_q == LAST_IDX)) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = LOAD;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= LOAD;
            idx_q   <= '0;
            for (int s = 0; s < N_ELEM; s++) begin
                slot_q[s] <= '0;
            end
        end else begin
            state_q <= state_d;
            if (in_fire) begin
                // Counter wraps naturally from 15 back to 0 for the next block.
                idx_q           <= idx_q + 1'b1;
                slot_q[wr_slot] <= in_data;
            end
        end
    end

    // Slots are never cleared on a block transfer; the next block overwrites them.
    for (genvar s = 0; s < N_ELEM; s++) begin : g_pack
        assign out_data[s*DATA_WIDTH +: DATA_WIDTH] = slot_q[s];
    end

`ifdef BITONIC_RUN_CHECK_EN
    logic [DATA_WIDTH-1:0] prev_q;
    logic                  err_q;
    logic                  run_start;
    logic                  out_fire;

    // Elements 0 and 8 open a new run and have no predecessor to compare with.
    assign run_start = (idx_q == '0) || (idx_q == HALF_IDX);
    assign out_fire  = out_valid & out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q <= '0;
            err_q  <= 1'b0;
        end else begin
            if (out_fire) begin
                err_q <= 1'b0;
            end else if (in_fire && !run_start && (in_data < prev_q)) begin
                err_q <= 1'b1;
            end
            if (in_fire) begin
                prev_q <= in_data;
            end
        end
    end

    assign run_err = err_q;
`else
    assign run_err = 1'b0;
`endif

endmodule
